// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART frame receiver and its FIFO fetch
//   helper: parser state encoding, start-of-frame byte, error counter
//   width, and the default receive-FIFO counter width.
package uart_frame_pkg;

  // Must track the counter width of the UART receive FIFO.
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int CNT_W_DEFAULT       = UART_FIFO_COUNTER_W;

  localparam logic [7:0] SOF_BYTE = 8'h7E;
  localparam int         ERR_W    = 8;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fetch.sv
// uart_rx_fetch
//   Pops bytes from a UART receive FIFO (head byte on rdr, occupancy on
//   rf_count) and presents each popped byte as a one-cycle strobe.
//   A guard flag blocks the cycle after every pop so the FIFO count has
//   time to settle; pops are therefore at least 2 cycles apart.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   fetch_en   allow popping this cycle
//   rdr        FIFO head byte (valid when rf_count != 0)
//   rf_count   FIFO occupancy
//   rf_pop     one-cycle pop pulse to the FIFO
//   byte_q     byte captured on the last pop
//   byte_stb   one-cycle strobe, high while byte_q holds a fresh byte
module uart_rx_fetch
  import uart_frame_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic [7:0]       rdr,
  input  logic [CNT_W-1:0] rf_count,
  output logic             rf_pop,
  output logic [7:0]       byte_q,
  output logic             byte_stb
);

  logic guard_q;
  logic take;

  assign take = fetch_en && !guard_q && (rf_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      guard_q  <= 1'b0;
      rf_pop   <= 1'b0;
      byte_stb <= 1'b0;
      byte_q   <= '0;
    end else begin
      guard_q  <= take;
      rf_pop   <= take;
      byte_stb <= take;
      if (take) begin
        byte_q <= rdr;
      end
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Parses bytes from the UART receive FIFO into frames
//   SOF, LEN, LEN payload bytes, CHK, where LEN + payload + CHK sums to
//   zero modulo 256. Only frames that pass the length and checksum tests
//   are replayed downstream from a payload buffer.
//   Handshake: a beat transfers on a cycle where out_valid and out_ready
//   are both high; while out_valid is high and out_ready low, out_data,
//   out_valid and out_last hold; out_last flags the final payload byte.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdr, rf_count       UART receive FIFO head byte and occupancy
//   rf_pop              pop pulse to the UART receive FIFO
//   out_data/valid/last payload stream, out_ready from downstream
//   err_cnt             saturating count of rejected/aborted frames
//   busy                high whenever the parser is not hunting for SOF
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter int         CNT_W   = CNT_W_DEFAULT,
  parameter int         TIMEOUT = 65535,
  parameter logic [7:0] SOF     = SOF_BYTE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rdr,
  input  logic [CNT_W-1:0] rf_count,
  output logic             rf_pop,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int         PTR_W     = $clog2(MAX_LEN + 1);
  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] len_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [7:0]       sum_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [7:0]       pay_buf [MAX_LEN];

  logic       fetch_en;
  logic [7:0] byte_q;
  logic       byte_stb;
  logic       timed;
  logic       to_hit;
  logic       len_ok;
  logic [7:0] chk_sum;
  logic       err_inc;
  logic       beat;

  uart_rx_fetch #(
    .CNT_W (CNT_W)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .rdr      (rdr),
    .rf_count (rf_count),
    .rf_pop   (rf_pop),
    .byte_q   (byte_q),
    .byte_stb (byte_stb)
  );

  // Bytes arriving while a frame is being drained stay in the UART FIFO.
  assign fetch_en = (state_q != ST_DRAIN);

  assign timed   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                   (state_q == ST_CHK);
  assign to_hit  = timed && (to_cnt_q == TO_W'(TIMEOUT));
  assign len_ok  = (byte_q != 8'h00) && (byte_q <= MAX_LEN_B);
  assign chk_sum = sum_q + byte_q;

  assign busy      = (state_q != ST_HUNT);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && (rd_ptr_q == len_q - PTR_W'(1));
  assign out_data  = out_valid ? pay_buf[rd_ptr_q[IDX_W-1:0]] : 8'h00;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (byte_stb && (byte_q == SOF)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (byte_stb) begin
          if (len_ok) begin
            state_d = ST_PAYLOAD;
          end else begin
            err_inc = 1'b1;
            state_d = ST_HUNT;
          end
        end else if (to_hit) begin
          err_inc = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (byte_stb) begin
          if (wr_ptr_q == len_q - PTR_W'(1)) state_d = ST_CHK;
        end else if (to_hit) begin
          err_inc = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (byte_stb) begin
          if (chk_sum == 8'h00) begin
            state_d = ST_DRAIN;
          end else begin
            err_inc = 1'b1;
            state_d = ST_HUNT;
          end
        end else if (to_hit) begin
          err_inc = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_DRAIN: begin
        if (beat && out_last) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sum_q    <= '0;
      to_cnt_q <= '0;
      err_cnt  <= '0;
    end else begin
      state_q <= state_d;

      // Idle timer restarts on every byte and on every state change.
      if (!timed || byte_stb || (state_d != state_q)) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (err_inc) begin
        err_cnt <= sat_inc(err_cnt);
      end

      if ((state_q == ST_LEN) && byte_stb && len_ok) begin
        len_q    <= byte_q[PTR_W-1:0];
        sum_q    <= byte_q;
        wr_ptr_q <= '0;
      end

      if ((state_q == ST_PAYLOAD) && byte_stb) begin
        sum_q    <= sum_q + byte_q;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end

      if ((state_q == ST_CHK) && byte_stb) begin
        rd_ptr_q <= '0;
      end else if (beat) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Payload storage carries no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if ((state_q == ST_PAYLOAD) && byte_stb) begin
      pay_buf[wr_ptr_q[IDX_W-1:0]] <= byte_q;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rdr = 8'h00;
  logic [4:0] rf_count = 5'd0;
  logic       out_ready = 1'b0;
  logic       rf_pop;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] err_cnt;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (5),
    .TIMEOUT (TIMEOUT),
    .SOF     (8'h7E)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdr       (rdr),
    .rf_count  (rf_count),
    .rf_pop    (rf_pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  // ---------------- bench state ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] batch_q[$];
  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int exp_err = 0;

  typedef struct {
    int first;
    int n;
    int beats;
    int err;
  } vec_t;
  vec_t       vecs[$];
  logic [7:0] tab_bytes[$];
  int         vec_first = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- FIFO model + scoreboard (negedge) ----------------
  logic       prev_pop = 1'b0;
  logic       prev_rst = 1'b1;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_word = 9'h0;

  always @(negedge clk) begin
    logic [7:0] tmp;
    logic [8:0] w;
    if (rf_pop) begin
      check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      check("pop_spacing", 32'(prev_pop), 32'd0);
      if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
    end
    prev_pop = rf_pop;

    if (!rst && !prev_rst && stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_word", 32'({out_last, out_data}), 32'(stall_word));
    end
    stall_prev = out_valid && !out_ready && !rst;
    stall_word = {out_last, out_data};

    if (out_valid && out_ready && !rst) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat: got unexpected %h, expected none", {out_last, out_data});
      end else begin
        w = exp_q.pop_front();
        check("beat", 32'({out_last, out_data}), 32'(w));
      end
    end
    prev_rst = rst;

    rdr      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    rf_count = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
  end

  // ---------------- reference model ----------------
  // Scans a complete byte stream: skip to SOF, reject bad lengths,
  // accept frames whose LEN + payload + CHK sums to 0 mod 256.
  task automatic model_batch();
    int i;
    int n;
    int len;
    logic [7:0] sum;
    i = 0;
    n = batch_q.size();
    while (i < n) begin
      if (batch_q[i] != 8'h7E) begin
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      len = int'(batch_q[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        if (exp_err < 255) exp_err++;
        i += 2;
        continue;
      end
      if (i + 2 + len >= n) break;
      sum = 8'h00;
      for (int k = 0; k <= len + 1; k++) sum = sum + batch_q[i+1+k];
      if (sum == 8'h00) begin
        for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), batch_q[i+2+k]});
      end else if (exp_err < 255) begin
        exp_err++;
      end
      i += len + 3;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_batch();
    model_batch();
    foreach (batch_q[j]) fifo_q.push_back(batch_q[j]);
    batch_q.delete();
  endtask

  task automatic add_good(input int len);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'(len);
    batch_q.push_back(8'h7E);
    batch_q.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      s = s + b;
      batch_q.push_back(b);
    end
    batch_q.push_back(8'h00 - s);
  endtask

  task automatic add_badchk(input int len);
    add_good(len);
    batch_q[batch_q.size()-1] = batch_q[batch_q.size()-1] ^ 8'($urandom_range(1, 255));
  endtask

  task automatic add_badlen();
    batch_q.push_back(8'h7E);
    if ($urandom_range(0, 1) == 0) batch_q.push_back(8'h00);
    else batch_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
  endtask

  task automatic add_garbage();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h7E) b = 8'h00;
    batch_q.push_back(b);
  endtask

  // mode 0: out_ready held high; mode 1: random out_ready
  task automatic wait_idle(input int mode);
    int quiet;
    int cyc;
    quiet = 0;
    cyc = 0;
    while (quiet < 4 && cyc < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      if (fifo_q.size() == 0 && !busy && !out_valid) quiet++;
      else quiet = 0;
    end
    check("idle_reached", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic vb(input logic [7:0] b);
    tab_bytes.push_back(b);
  endtask

  task automatic ve(input int beats, input int err);
    vec_t v;
    v.first = vec_first;
    v.n     = tab_bytes.size() - vec_first;
    v.beats = beats;
    v.err   = err;
    vecs.push_back(v);
    vec_first = tab_bytes.size();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tab_err;
    int beats0;
    logic seen;
    logic [7:0] pat[4];

    // Vector table: byte stream, expected beats, expected error increment.
    vb(8'h7E); vb(8'h03); vb(8'h11); vb(8'h22); vb(8'h33); vb(8'h97); ve(3, 0);
    vb(8'h7E); vb(8'h02); vb(8'hAA); vb(8'hBB); vb(8'h00); ve(0, 1);
    vb(8'h7E); vb(8'h01); vb(8'h5A); vb(8'hA5); ve(1, 0);
    vb(8'h00); vb(8'hFF); vb(8'h7E); vb(8'h00); ve(0, 1);
    vb(8'h7E); vb(8'h11); ve(0, 1);
    vb(8'h7E); vb(8'h02); vb(8'h7E); vb(8'h7E); vb(8'h02); ve(2, 0);
    vb(8'h7E); vb(8'h10);
    for (int k = 0; k < 16; k++) vb(8'(k));
    vb(8'h78); ve(16, 0);
    vb(8'h7E); vb(8'h01); vb(8'h00); vb(8'hFF); ve(1, 0);

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rf_pop", 32'(rf_pop), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    tab_err = 0;
    for (int v = 0; v < vecs.size(); v++) begin
      for (int j = 0; j < vecs[v].n; j++) batch_q.push_back(tab_bytes[vecs[v].first + j]);
      beats0 = acc_cnt;
      flush_batch();
      wait_idle(0);
      tab_err += vecs[v].err;
      check($sformatf("vec%0d_beats", v), 32'(acc_cnt - beats0), 32'(vecs[v].beats));
      check($sformatf("vec%0d_err", v), 32'(err_cnt), 32'(tab_err));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end

    // Backpressure: 4-byte frame, second frame queued behind it
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    batch_q.push_back(8'h7E); batch_q.push_back(8'h04);
    batch_q.push_back(8'hA1); batch_q.push_back(8'hB2);
    batch_q.push_back(8'hC3); batch_q.push_back(8'hD4);
    batch_q.push_back(8'h12);
    batch_q.push_back(8'h7E); batch_q.push_back(8'h01);
    batch_q.push_back(8'h5A); batch_q.push_back(8'hA5);
    beats0 = acc_cnt;
    flush_batch();
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      out_ready = pat[k % 4];
      tick();
      if (out_valid && out_last && (acc_cnt - beats0 == 3)) begin
        seen = 1'b1;
        check("bp_second_frame_queued", 32'(fifo_q.size()), 32'd4);
      end
    end
    check("bp_last_seen", 32'(seen), 32'd1);
    wait_idle(0);
    check("bp_beats", 32'(acc_cnt - beats0), 32'd5);
    check("bp_err", 32'(err_cnt), 32'(exp_err));

    // Timeout: frame stops after one payload byte
    batch_q.push_back(8'h7E); batch_q.push_back(8'h02); batch_q.push_back(8'h10);
    flush_batch();
    out_ready = 1'b1;
    repeat (60) tick();
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_err_before", 32'(err_cnt), 32'(exp_err));
    repeat (60) tick();
    exp_err++;
    check("to_err_after", 32'(err_cnt), 32'(exp_err));
    check("to_busy_after", 32'(busy), 32'd0);
    beats0 = acc_cnt;
    add_good(3);
    flush_batch();
    wait_idle(0);
    check("to_next_beats", 32'(acc_cnt - beats0), 32'd3);

    // Randomized batches against the model
    for (int r = 0; r < 25; r++) begin
      int items;
      int kind;
      items = $urandom_range(1, 4);
      for (int t = 0; t < items; t++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 4) add_good($urandom_range(1, MAX_LEN));
        else if (kind <= 6) add_badchk($urandom_range(1, MAX_LEN));
        else if (kind == 7) add_badlen();
        else repeat ($urandom_range(1, 3)) add_garbage();
      end
      flush_batch();
      wait_idle(1);
      check($sformatf("rand%0d_err", r), 32'(err_cnt), 32'(exp_err));
      check($sformatf("rand%0d_drained", r), 32'(exp_q.size()), 32'd0);
    end

    // Reset mid-drain
    out_ready = 1'b0;
    add_good(5);
    flush_batch();
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rd_drain_reached", 32'(seen), 32'd1);
    check("rd_err_nonzero", 32'(err_cnt != 8'h00), 32'd1);
    rst = 1'b1;
    tick();
    check("rd_out_valid", 32'(out_valid), 32'd0);
    check("rd_err_cnt", 32'(err_cnt), 32'd0);
    check("rd_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_err = 0;
    wait_idle(0);

    // Saturation: bad-length frames
    repeat (254) begin
      batch_q.push_back(8'h7E);
      batch_q.push_back(8'h00);
    end
    flush_batch();
    wait_idle(0);
    check("sat_254", 32'(err_cnt), 32'hFE);
    repeat (46) begin
      batch_q.push_back(8'h7E);
      batch_q.push_back(8'h00);
    end
    flush_batch();
    wait_idle(0);
    check("sat_300", 32'(err_cnt), 32'hFF);
    check("sat_model", 32'(err_cnt), 32'(exp_err));

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
